// File: rtl/servo_ramp_sequencer_if.sv
// Target-write and downstream servo-load signals for servo_ramp_sequencer.
// The host side drives writes; the sequencer drives the latch/address/dutycycle bus.
interface servo_ramp_sequencer_if #(
    parameter int unsigned nbits = 2
);
    logic             wr_en;
    logic [nbits-1:0] wr_addr;
    logic [7:0]       wr_data;
    logic [nbits-1:0] address;
    logic             latch;
    logic [7:0]       dutycycle;
    logic             frame_done;
    logic             overrun;

    modport master (
        output wr_en, wr_addr, wr_data,
        input  address, latch, dutycycle, frame_done, overrun
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        output address, latch, dutycycle, frame_done, overrun
    );
endinterface

// File: rtl/servo_ramp_sequencer.sv
// Periodically walks every servo channel, moving current position toward its
// target by at most `step` per update, and emits each position as a one-cycle load.
module servo_ramp_sequencer #(
    parameter int unsigned n_channels    = 4,
    parameter int unsigned nbits         = (n_channels > 1) ? $clog2(n_channels) : 1,
    parameter int unsigned clk_frequency = 50000000,
    parameter int unsigned update_hz     = 50,
    parameter int unsigned step          = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    servo_ramp_sequencer_if.slave bus
);
    localparam int unsigned TICK_DIV = clk_frequency / update_hz;
    localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [nbits-1:0] CH_LAST  = nbits'(n_channels - 1);
    localparam logic [7:0]       STEP     = 8'(step);

    typedef enum logic [1:0] {IDLE, CALC, EMIT} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [nbits-1:0] ch_q, ch_d;
    logic [7:0]       target_q  [n_channels];
    logic [7:0]       target_d  [n_channels];
    logic [7:0]       current_q [n_channels];
    logic [7:0]       current_d [n_channels];
    logic [nbits-1:0] address_q, address_d;
    logic [7:0]       duty_q, duty_d;
    logic             latch_q, latch_d;
    logic             frame_done_q, frame_done_d;
    logic             overrun_q, overrun_d;

    logic             tick;
    logic [7:0]       cur_sel;
    logic [7:0]       tgt_sel;
    logic [7:0]       next_pos;

    // Next-state, ramp arithmetic and registered-output values.
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        target_d     = target_q;
        current_d    = current_q;
        address_d    = address_q;
        duty_d       = duty_q;
        latch_d      = 1'b0;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;
        cur_sel      = 8'd0;
        tgt_sel      = 8'd0;
        next_pos     = 8'd0;

        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

        // Loop compares keep out-of-range addresses from aliasing onto a real channel.
        for (int unsigned i = 0; i < n_channels; i++) begin
            if (bus.wr_en && (bus.wr_addr == nbits'(i))) begin
                target_d[i] = bus.wr_data;
            end
            if (ch_q == nbits'(i)) begin
                cur_sel = current_q[i];
                tgt_sel = target_q[i];
            end
        end

        if (tgt_sel > cur_sel) begin
            next_pos = ((tgt_sel - cur_sel) > STEP) ? cur_sel + STEP : tgt_sel;
        end else if (tgt_sel < cur_sel) begin
            next_pos = ((cur_sel - tgt_sel) > STEP) ? cur_sel - STEP : tgt_sel;
        end else begin
            next_pos = cur_sel;
        end

        if (tick && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (tick) begin
                    ch_d    = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                for (int unsigned i = 0; i < n_channels; i++) begin
                    if (ch_q == nbits'(i)) begin
                        current_d[i] = next_pos;
                    end
                end
                latch_d   = 1'b1;
                address_d = ch_q;
                duty_d    = next_pos;
                state_d   = EMIT;
            end
            EMIT: begin
                if (ch_q != CH_LAST) begin
                    ch_d    = ch_q + nbits'(1);
                    state_d = CALC;
                end else begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ch_q         <= '0;
            target_q     <= '{default: 8'd0};
            current_q    <= '{default: 8'd0};
            address_q    <= '0;
            duty_q       <= 8'd0;
            latch_q      <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ch_q         <= ch_d;
            target_q     <= target_d;
            current_q    <= current_d;
            address_q    <= address_d;
            duty_q       <= duty_d;
            latch_q      <= latch_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.address    = address_q;
    assign bus.dutycycle  = duty_q;
    assign bus.latch      = latch_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_servo_ramp_sequencer.sv
// Bench for servo_ramp_sequencer: three configurations checked every cycle against
// a timing/ramp model, plus literal expectations for latency and ramp sequences.
module tb_servo_ramp_sequencer;
    localparam int NCH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: step 1, div 10, 3-bit address. 1: step 50. 2: div 5 (overrun case).
    int DIV [3] = '{10, 10, 5};
    int STP [3] = '{1, 50, 1};

    logic       rst_i     [3];
    logic       wr_en_i   [3];
    logic [2:0] wr_addr_i [3];
    logic [7:0] wr_data_i [3];
    logic       lat_o     [3];
    logic [2:0] addr_o    [3];
    logic [7:0] duty_o    [3];
    logic       fd_o      [3];
    logic       ov_o      [3];

    servo_ramp_sequencer_if #(.nbits(3)) ifa ();
    servo_ramp_sequencer_if #(.nbits(2)) ifb ();
    servo_ramp_sequencer_if #(.nbits(2)) ifc ();

    assign ifa.wr_en   = wr_en_i[0];
    assign ifa.wr_addr = wr_addr_i[0];
    assign ifa.wr_data = wr_data_i[0];
    assign ifb.wr_en   = wr_en_i[1];
    assign ifb.wr_addr = wr_addr_i[1][1:0];
    assign ifb.wr_data = wr_data_i[1];
    assign ifc.wr_en   = wr_en_i[2];
    assign ifc.wr_addr = wr_addr_i[2][1:0];
    assign ifc.wr_data = wr_data_i[2];

    assign lat_o[0] = ifa.latch;  assign addr_o[0] = ifa.address;
    assign lat_o[1] = ifb.latch;  assign addr_o[1] = {1'b0, ifb.address};
    assign lat_o[2] = ifc.latch;  assign addr_o[2] = {1'b0, ifc.address};
    assign duty_o[0] = ifa.dutycycle; assign fd_o[0] = ifa.frame_done; assign ov_o[0] = ifa.overrun;
    assign duty_o[1] = ifb.dutycycle; assign fd_o[1] = ifb.frame_done; assign ov_o[1] = ifb.overrun;
    assign duty_o[2] = ifc.dutycycle; assign fd_o[2] = ifc.frame_done; assign ov_o[2] = ifc.overrun;

    servo_ramp_sequencer #(.n_channels(4), .nbits(3), .clk_frequency(1000), .update_hz(100), .step(1))
        u_a (.clk(clk), .reset(rst_i[0]), .bus(ifa));
    servo_ramp_sequencer #(.n_channels(4), .nbits(2), .clk_frequency(1000), .update_hz(100), .step(50))
        u_b (.clk(clk), .reset(rst_i[1]), .bus(ifb));
    servo_ramp_sequencer #(.n_channels(4), .nbits(2), .clk_frequency(500), .update_hz(100), .step(1))
        u_c (.clk(clk), .reset(rst_i[2]), .bus(ifc));

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   r0 [3] = '{0, 0, 0};
    logic chk_on = 1'b0;

    // Model state: tick phase, scan start cycle, target/current arrays, expected outputs.
    int         m_cnt [3] = '{0, 0, 0};
    int         m_T   [3] = '{-1, -1, -1};
    logic       m_ov  [3];
    logic [7:0] m_tgt [3][NCH];
    logic [7:0] m_cur [3][NCH];
    logic       e_lat [3];
    logic [2:0] e_addr[3];
    logic [7:0] e_duty[3];
    logic       e_fd  [3];
    logic       e_ov  [3];

    task automatic model_step(input int i);
        int off, k, d;
        bit tick, busy;
        if (rst_i[i] === 1'b1) begin
            for (int c = 0; c < NCH; c++) begin
                m_tgt[i][c] = 8'd0;
                m_cur[i][c] = 8'd0;
            end
            m_cnt[i] = 0; m_T[i] = -1; m_ov[i] = 1'b0;
            e_lat[i] = 1'b0; e_addr[i] = 3'd0; e_duty[i] = 8'd0; e_fd[i] = 1'b0; e_ov[i] = 1'b0;
            return;
        end
        e_lat[i] = 1'b0;
        e_fd[i]  = 1'b0;
        tick = (m_cnt[i] == DIV[i] - 1);
        busy = (m_T[i] >= 0);
        if (busy) begin
            // Odd offsets after the tick are the per-channel update cycles.
            off = cyc - m_T[i];
            if (off % 2 == 1) begin
                k = (off - 1) / 2;
                d = int'(m_tgt[i][k]) - int'(m_cur[i][k]);
                if (d > STP[i])  d = STP[i];
                if (d < -STP[i]) d = -STP[i];
                m_cur[i][k] = 8'(int'(m_cur[i][k]) + d);
                e_lat[i]  = 1'b1;
                e_addr[i] = 3'(k);
                e_duty[i] = m_cur[i][k];
            end else if (off == 2 * NCH) begin
                e_fd[i] = 1'b1;
                m_T[i]  = -1;
            end
        end
        if (tick) begin
            if (busy) m_ov[i] = 1'b1;
            else      m_T[i]  = cyc;
        end
        if (wr_en_i[i] === 1'b1 && int'(wr_addr_i[i]) < NCH)
            m_tgt[i][int'(wr_addr_i[i])] = wr_data_i[i];
        m_cnt[i] = (m_cnt[i] + 1) % DIV[i];
        e_ov[i]  = m_ov[i];
    endtask

    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) model_step(i);
            cyc++;
        end
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s inst%0d cyc=%0d got=%0h want=%0h", nm, inst, cyc, got, exp);
        end
    endtask

    task automatic lit(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, exp);
        end
    endtask

    // Per-cycle compare of every instance against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                for (int i = 0; i < 3; i++) begin
                    chk("latch", i, 32'(lat_o[i]), 32'(e_lat[i]));
                    chk("address", i, 32'(addr_o[i]), 32'(e_addr[i]));
                    chk("dutycycle", i, 32'(duty_o[i]), 32'(e_duty[i]));
                    chk("frame_done", i, 32'(fd_o[i]), 32'(e_fd[i]));
                    chk("overrun", i, 32'(ov_o[i]), 32'(e_ov[i]));
                end
            end
        end
    end

    // ch == NCH waits for frame_done instead of a channel latch.
    task automatic wait_evt(input int inst, input int ch, output logic [7:0] d, output int rel);
        bit hit;
        hit = 1'b0;
        d   = 8'd0;
        rel = -1;
        for (int n = 0; n < 60 && !hit; n++) begin
            @(negedge clk);
            if ((ch == NCH) ? (fd_o[inst] === 1'b1)
                            : (lat_o[inst] === 1'b1 && int'(addr_o[inst]) == ch)) begin
                hit = 1'b1;
                d   = duty_o[inst];
                rel = cyc - r0[inst];
            end
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL timeout inst%0d ch%0d", inst, ch);
        end
    endtask

    task automatic wr(input int inst, input int a, input int dt);
        @(negedge clk);
        wr_en_i[inst] = 1'b1; wr_addr_i[inst] = 3'(a); wr_data_i[inst] = 8'(dt);
        @(negedge clk);
        wr_en_i[inst] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int rel;
        int ramp_a [4] = '{1, 2, 3, 3};
        int up_b   [4] = '{50, 100, 150, 200};
        int down_b [5] = '{150, 100, 50, 20, 20};

        for (int i = 0; i < 3; i++) begin
            rst_i[i] = 1'b1; wr_en_i[i] = 1'b0; wr_addr_i[i] = 3'd0; wr_data_i[i] = 8'd0;
        end
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rst_i[i] = 1'b0;
            r0[i]    = cyc;
        end
        lit("reset_overrun", int'(ov_o[2]), 0);
        lit("reset_duty", int'(duty_o[0]), 0);

        // First scan after reset: tick in cycle 9, ch0 at 11, frame_done at 18.
        wait_evt(0, 0, d, rel);
        lit("first_latch_cycle", rel, 11);
        lit("first_latch_duty", int'(d), 0);
        wait_evt(0, NCH, d, rel);
        lit("first_frame_cycle", rel, 18);

        wr(0, 2, 3);
        for (int j = 0; j < 4; j++) begin
            wait_evt(0, 2, d, rel);
            lit("ch2_ramp", int'(d), ramp_a[j]);
        end

        // Out-of-range write must not touch any channel.
        wr(0, 4, 9);
        wait_evt(0, 3, d, rel);
        wait_evt(0, 0, d, rel);
        lit("oob_ch0", int'(d), 0);

        // Write target[1] during ch1's update cycle: old target used this scan.
        @(negedge clk);
        wr_en_i[0] = 1'b1; wr_addr_i[0] = 3'd1; wr_data_i[0] = 8'd7;
        wait_evt(0, 1, d, rel);
        wr_en_i[0] = 1'b0;
        lit("calc_write_same_scan", int'(d), 0);
        wait_evt(0, 1, d, rel);
        lit("calc_write_next_scan", int'(d), 1);

        // Reset mid-scan, two cycles after ch0's latch.
        wait_evt(0, 0, d, rel);
        @(negedge clk);
        @(negedge clk);
        rst_i[0] = 1'b1;
        @(negedge clk);
        rst_i[0] = 1'b0;
        r0[0]    = cyc;
        lit("midscan_rst_latch", int'(lat_o[0]), 0);
        lit("midscan_rst_duty", int'(duty_o[0]), 0);
        wait_evt(0, 0, d, rel);
        lit("post_rst_latch_cycle", rel, 11);

        // Large step ramps up, then down to 20 without underflow.
        wait_evt(1, NCH, d, rel);
        wr(1, 1, 200);
        for (int j = 0; j < 4; j++) begin
            wait_evt(1, 1, d, rel);
            lit("step50_up", int'(d), up_b[j]);
        end
        wait_evt(1, NCH, d, rel);
        wr(1, 1, 20);
        for (int j = 0; j < 5; j++) begin
            wait_evt(1, 1, d, rel);
            lit("step50_down", int'(d), down_b[j]);
        end

        // Short tick period: overrun is sticky until reset, then returns.
        lit("overrun_sticky", int'(ov_o[2]), 1);
        @(negedge clk);
        rst_i[2] = 1'b1;
        @(negedge clk);
        rst_i[2] = 1'b0;
        r0[2]    = cyc;
        lit("overrun_cleared", int'(ov_o[2]), 0);
        repeat (15) @(negedge clk);
        lit("overrun_again", int'(ov_o[2]), 1);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
